// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: controller states,
// stall-cause codes, the hardwired zero register and the ID/EX match helper.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_BR_WAIT  = 2'd1,
      ST_MDU_WAIT = 2'd2
   } hz_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_LOAD_USE = 2'd1,
      CAUSE_BRANCH   = 2'd2,
      CAUSE_MDU      = 2'd3
   } stall_cause_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when the EX destination feeds a source operand of the ID instruction.
   // $0 is never a real dependency, and rt only counts when it is read.
   function automatic logic reg_hit(input logic [4:0] dst,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       rt_used);
      return (dst != REG_ZERO) && ((dst == rs) || (rt_used && (dst == rt)));
   endfunction

endpackage

// File: rtl/mdu_wait_counter.sv
// Down-counter that tracks the remaining extra cycles a mult/div holds EX.
// Loaded with MDU_LATENCY-2 when the op starts; the zero flag marks the last
// wait cycle.
module mdu_wait_counter
   import mips_pipe_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   localparam int W = $clog2(MDU_LATENCY)
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [W-1:0] LOAD_VAL = W'(MDU_LATENCY - 2);
   localparam logic [W-1:0] ONE      = W'(1);

   logic [W-1:0] count;

   // Load on MDU start, otherwise count down towards zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core. Covers the hazards the
// EX forwarding unit cannot: load-use, branch operands needed in ID and the
// multi-cycle MDU. Drives PC / pipeline-register write enables and bubble
// controls, and keeps a saturating count of stalled cycles.
module hazard_stall_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RsAddr_id,
   input  logic [4:0]       RtAddr_id,
   input  logic             RtUsed_id,
   input  logic             Branch_id,
   input  logic             BranchTaken_id,
   input  logic             MemRead_ex,
   input  logic             RegWrite_ex,
   input  logic [4:0]       RegWriteAddr_ex,
   input  logic             MduStart_ex,
   input  logic             ClrStat,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             ID_EX_Flush,
   output logic             IF_ID_Flush,
   output logic             EX_MEM_Flush,
   output logic [1:0]       StallCause,
   output logic [CNT_W-1:0] StallCycles
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   hz_state_t        state;
   hz_state_t        state_next;
   stall_cause_t     cause;
   logic             hit;
   logic             mdu_load;
   logic             mdu_dec;
   logic             mdu_zero;
   logic [CNT_W-1:0] stall_cycles;

   assign hit = reg_hit(RegWriteAddr_ex, RsAddr_id, RtAddr_id, RtUsed_id);

   mdu_wait_counter #(
      .MDU_LATENCY (MDU_LATENCY)
   ) u_mdu_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (mdu_load),
      .dec   (mdu_dec),
      .zero  (mdu_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. Defaults are the free-running pipeline;
   // a taken branch only squashes IF/ID when nothing is stalling, so a branch
   // stuck in ID re-resolves after release.
   always_comb begin
      state_next   = state;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      ID_EX_Flush  = 1'b0;
      IF_ID_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      cause        = CAUSE_NONE;
      mdu_load     = 1'b0;
      mdu_dec      = 1'b0;

      case (state)
         ST_RUN: begin
            if (MduStart_ex) begin
               // Hold everything upstream of EX; EX/MEM sees bubbles.
               PC_Write     = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Flush = 1'b1;
               cause        = CAUSE_MDU;
               mdu_load     = 1'b1;
               state_next   = ST_MDU_WAIT;
            end else if (MemRead_ex && hit && Branch_id) begin
               // Load value reaches ID two cycles late: stall here and again
               // in BR_WAIT while the load is in MEM.
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Write = 1'b0;
               ID_EX_Flush = 1'b1;
               cause       = CAUSE_BRANCH;
               state_next  = ST_BR_WAIT;
            end else if (MemRead_ex && hit) begin
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Write = 1'b0;
               ID_EX_Flush = 1'b1;
               cause       = CAUSE_LOAD_USE;
            end else if (Branch_id && RegWrite_ex && hit) begin
               // ALU result is needed by the ID comparator one cycle early.
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Write = 1'b0;
               ID_EX_Flush = 1'b1;
               cause       = CAUSE_BRANCH;
            end else if (BranchTaken_id) begin
               IF_ID_Flush = 1'b1;
            end
         end

         ST_BR_WAIT: begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            cause       = CAUSE_BRANCH;
            state_next  = ST_RUN;
         end

         ST_MDU_WAIT: begin
            // A repeated MduStart_ex here is the same held op and is ignored.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            cause        = CAUSE_MDU;
            if (mdu_zero) begin
               state_next = ST_RUN;
            end else begin
               mdu_dec = 1'b1;
            end
         end

         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   assign StallCause = cause;

   // Saturating stall-cycle statistic; a clear wins over a same-cycle stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (ClrStat) begin
         stall_cycles <= '0;
      end else if (!PC_Write && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_ONE;
      end
   end

   assign StallCycles = stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each stimulus cycle pushes the
// hand-computed controls and expected statistic; a monitor pops and compares
// on the falling edge.
module tb_hazard_stall_ctrl;

   // {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Flush, IF_ID_Flush, EX_MEM_Flush, StallCause}
   localparam logic [7:0] E_RUN = 8'b111_000_00;
   localparam logic [7:0] E_LU  = 8'b000_100_01;
   localparam logic [7:0] E_BR  = 8'b000_100_10;
   localparam logic [7:0] E_MDU = 8'b000_001_11;
   localparam logic [7:0] E_BT  = 8'b111_010_00;

   typedef struct {
      int         tid;
      logic [7:0] outs;
      logic [3:0] cnt;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] RsAddr_id;
   logic [4:0] RtAddr_id;
   logic       RtUsed_id;
   logic       Branch_id;
   logic       BranchTaken_id;
   logic       MemRead_ex;
   logic       RegWrite_ex;
   logic [4:0] RegWriteAddr_ex;
   logic       MduStart_ex;
   logic       ClrStat;
   logic       PC_Write;
   logic       IF_ID_Write;
   logic       ID_EX_Write;
   logic       ID_EX_Flush;
   logic       IF_ID_Flush;
   logic       EX_MEM_Flush;
   logic [1:0] StallCause;
   logic [3:0] StallCycles;

   exp_t       sb_q[$];
   logic [3:0] cnt_model;
   int         tests_run;
   int         tests_failed;

   hazard_stall_ctrl #(
      .MDU_LATENCY (4),
      .CNT_W       (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .RsAddr_id       (RsAddr_id),
      .RtAddr_id       (RtAddr_id),
      .RtUsed_id       (RtUsed_id),
      .Branch_id       (Branch_id),
      .BranchTaken_id  (BranchTaken_id),
      .MemRead_ex      (MemRead_ex),
      .RegWrite_ex     (RegWrite_ex),
      .RegWriteAddr_ex (RegWriteAddr_ex),
      .MduStart_ex     (MduStart_ex),
      .ClrStat         (ClrStat),
      .PC_Write        (PC_Write),
      .IF_ID_Write     (IF_ID_Write),
      .ID_EX_Write     (ID_EX_Write),
      .ID_EX_Flush     (ID_EX_Flush),
      .IF_ID_Flush     (IF_ID_Flush),
      .EX_MEM_Flush    (EX_MEM_Flush),
      .StallCause      (StallCause),
      .StallCycles     (StallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One stimulus cycle: drive inputs just after the edge, queue expectation,
   // then advance the statistic model by what this cycle should do.
   task automatic cyc(input int tid, input int rs, input int rt, input int rtu,
                      input int br, input int bt, input int mr, input int rw,
                      input int dst, input int mdu, input int clr,
                      input logic [7:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      RsAddr_id       = 5'(rs);
      RtAddr_id       = 5'(rt);
      RtUsed_id       = 1'(rtu);
      Branch_id       = 1'(br);
      BranchTaken_id  = 1'(bt);
      MemRead_ex      = 1'(mr);
      RegWrite_ex     = 1'(rw);
      RegWriteAddr_ex = 5'(dst);
      MduStart_ex     = 1'(mdu);
      ClrStat         = 1'(clr);
      x.tid  = tid;
      x.outs = e;
      x.cnt  = cnt_model;
      sb_q.push_back(x);
      if (!rst_n || (clr != 0)) begin
         cnt_model = 4'd0;
      end else if (!e[7] && (cnt_model != 4'hF)) begin
         cnt_model = cnt_model + 4'd1;
      end
   endtask

   task automatic idle(input int tid, input logic [7:0] e);
      cyc(tid, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
   endtask

   // Monitor: the controls are valid every cycle, so compare on each falling
   // edge for which an expectation is queued.
   initial begin
      forever begin
         exp_t       e;
         logic [7:0] act;
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Flush,
                   IF_ID_Flush, EX_MEM_Flush, StallCause};
            tests_run = tests_run + 2;
            if (act !== e.outs) begin
               tests_failed = tests_failed + 1;
               $display("[TB] FAIL case%0d ctrl: got %b expected %b", e.tid, act, e.outs);
            end
            if (StallCycles !== e.cnt) begin
               tests_failed = tests_failed + 1;
               $display("[TB] FAIL case%0d StallCycles: got %0d expected %0d",
                        e.tid, StallCycles, e.cnt);
            end
            $display("[TB] case%0d t=%0t ctrl=%b cnt=%0d", e.tid, $time, act, StallCycles);
         end
      end
   end

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      cnt_model       = 4'd0;
      rst_n           = 1'b0;
      RsAddr_id       = '0;
      RtAddr_id       = '0;
      RtUsed_id       = 1'b0;
      Branch_id       = 1'b0;
      BranchTaken_id  = 1'b0;
      MemRead_ex      = 1'b0;
      RegWrite_ex     = 1'b0;
      RegWriteAddr_ex = '0;
      MduStart_ex     = 1'b0;
      ClrStat         = 1'b0;

      // Reset state
      idle(0, E_RUN);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: lw $2 in EX, rs=$2 -> one load-use stall, then free
      cyc(1, 2, 0, 0, 0, 0, 1, 1, 2, 0, 0, E_LU);
      cyc(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

      // 2: $0 destination and unused rt never stall; used rt does
      cyc(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, E_RUN);
      cyc(2, 3, 7, 0, 0, 0, 1, 1, 7, 0, 0, E_RUN);
      cyc(2, 3, 7, 1, 0, 0, 1, 1, 7, 0, 0, E_LU);
      cyc(2, 3, 7, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN);

      // 3: lw $5 feeding beq in ID -> 2 stalls (taken ignored in BR_WAIT)
      cyc(3, 5, 0, 0, 1, 0, 1, 1, 5, 0, 0, E_BR);
      cyc(3, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, E_BR);
      cyc(3, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
      //    add $5 feeding beq -> exactly 1 stall
      cyc(3, 5, 6, 1, 1, 0, 0, 1, 5, 0, 0, E_BR);
      cyc(3, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, E_RUN);

      // 4: MDU start beats load-use and taken branch; 3 wait cycles, restart ignored
      cyc(4, 2, 0, 0, 0, 1, 1, 1, 2, 1, 0, E_MDU);
      idle(4, E_MDU);
      cyc(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MDU);
      idle(4, E_MDU);
      idle(4, E_RUN);

      // 5: taken branch squashes IF/ID only when not stalled
      cyc(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, E_BT);
      cyc(5, 4, 0, 0, 0, 1, 1, 1, 4, 0, 0, E_LU);
      cyc(5, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0, E_BT);
      idle(5, E_RUN);

      // 6: async reset mid-cycle while in MDU_WAIT
      cyc(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MDU);
      idle(6, E_MDU);
      begin
         exp_t x;
         @(posedge clk);
         #1;
         x.tid  = 6;
         x.outs = E_RUN;
         x.cnt  = 4'd0;
         sb_q.push_back(x);
         #1 rst_n = 1'b0;
         cnt_model = 4'd0;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      //    20 stall cycles saturate a 4-bit statistic at 15
      for (int i = 0; i < 20; i++) begin
         cyc(6, 3, 0, 0, 0, 0, 1, 1, 3, 0, 0, E_LU);
      end
      //    clear wins over a simultaneous stall
      cyc(6, 3, 0, 0, 0, 0, 1, 1, 3, 0, 1, E_LU);
      idle(6, E_RUN);
      idle(6, E_RUN);

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         tests_run    = tests_run + 1;
         tests_failed = tests_failed + 1;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
